// File: rtl/cp0_pkg.sv
// Coprocessor-0 shared definitions.
// Holds the CP0 register numbers, the exception codes written into Cause.ExcCode,
// the bit positions of the Status/Cause fields, and the event encoding used by the
// top-level priority logic to say which single event is taken in a cycle.
package cp0_pkg;

    localparam logic [4:0] CP0_STATUS = 5'd12;
    localparam logic [4:0] CP0_CAUSE  = 5'd13;
    localparam logic [4:0] CP0_EPC    = 5'd14;

    localparam logic [4:0] EXC_INT = 5'd0;
    localparam logic [4:0] EXC_SYS = 5'd8;

    localparam int IE_BIT  = 0;
    localparam int EXL_BIT = 1;
    localparam int IM_LSB  = 8;
    localparam int IP_LSB  = 8;
    localparam int EXC_LSB = 2;

    // At most one of these is acted on per cycle; the order of the labels
    // mirrors the priority, interrupt first.
    typedef enum logic [2:0] {
        EV_NONE,
        EV_INT,
        EV_SYS,
        EV_ERET,
        EV_MTC
    } cp0_event_e;

endpackage

// File: rtl/cp0_irq_sync.sv
// Single interrupt line conditioner.
// Brings one asynchronous, level-high interrupt line into the clock domain with a
// two-flop synchroniser and produces a one-cycle pulse on its synchronised rising edge.
// Ports:
//   clk     system clock
//   rst     synchronous active-high reset, clears all three flops
//   irq_i   raw asynchronous interrupt level
//   rise_o  high for one cycle, two edges after the line was first sampled high
module cp0_irq_sync (
    input  logic clk,
    input  logic rst,
    input  logic irq_i,
    output logic rise_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // meta_q/sync_q form the synchroniser; prev_q remembers the last synchronised
    // level so a held-high line produces only one pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= irq_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign rise_o = sync_q & ~prev_q;

endmodule

// File: rtl/cp0_unit.sv
// Coprocessor-0 responder for a single-cycle datapath.
// Holds Status, Cause and EPC, latches synchronised interrupt edges into Cause.IP,
// and decides exception entry (interrupt or syscall) and return (ERET).
// Ports:
//   clk, rst                     clock and synchronous active-high reset
//   stall                        datapath hold; blocks architectural updates
//   mfc0, mtc0, exce_ret, sys    decoder strobes
//   reg_sel, wdata               CP0 register number and mtc0 write data
//   pc                           address of the instruction in this cycle
//   irq                          asynchronous active-high interrupt lines
//   rdata                        mfc0 read data, pre-edge register value
//   redirect, redirect_pc, kill  combinational PC redirect and instruction kill
//   exl                          Status.EXL
module cp0_unit
    import cp0_pkg::*;
#(
    parameter int          NIRQ       = 4,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0800
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            mfc0,
    input  logic            mtc0,
    input  logic            exce_ret,
    input  logic            sys,
    input  logic [4:0]      reg_sel,
    input  logic [31:0]     wdata,
    input  logic [31:0]     pc,
    input  logic [NIRQ-1:0] irq,
    output logic [31:0]     rdata,
    output logic            redirect,
    output logic [31:0]     redirect_pc,
    output logic            kill,
    output logic            exl
);

    logic            ie_q,  ie_d;
    logic            exl_q, exl_d;
    logic [NIRQ-1:0] im_q,  im_d;
    logic [NIRQ-1:0] ip_q,  ip_d;
    logic [4:0]      exc_q, exc_d;
    logic [31:0]     epc_q, epc_d;

    logic [NIRQ-1:0] irqRise;
    cp0_event_e      evt;
    logic [31:0]     statusWord;
    logic [31:0]     causeWord;

    for (genvar g = 0; g < NIRQ; g++) begin : gIrq
        cp0_irq_sync uSync (
            .clk    (clk),
            .rst    (rst),
            .irq_i  (irq[g]),
            .rise_o (irqRise[g])
        );
    end

    // Pick the single event acted on this cycle. Nothing is taken during stall or
    // reset, so the datapath never sees a redirect in either.
    always_comb begin
        evt = EV_NONE;
        if (!rst && !stall) begin
            if (ie_q && !exl_q && |(ip_q & im_q)) evt = EV_INT;
            else if (sys)                          evt = EV_SYS;
            else if (exce_ret)                     evt = EV_ERET;
            else if (mtc0)                         evt = EV_MTC;
        end
    end

    // Next-state for the architectural registers. IP is OR-ed with the edge pulses
    // last so a new edge survives a simultaneous mtc0 clear of the same bit.
    always_comb begin
        ie_d  = ie_q;
        exl_d = exl_q;
        im_d  = im_q;
        ip_d  = ip_q;
        exc_d = exc_q;
        epc_d = epc_q;
        case (evt)
            EV_INT: begin
                epc_d = pc;
                exc_d = EXC_INT;
                exl_d = 1'b1;
            end
            EV_SYS: begin
                if (!exl_q) epc_d = pc;
                exc_d = EXC_SYS;
                exl_d = 1'b1;
            end
            EV_ERET: exl_d = 1'b0;
            EV_MTC: begin
                if (reg_sel == CP0_STATUS) begin
                    ie_d  = wdata[IE_BIT];
                    exl_d = wdata[EXL_BIT];
                    im_d  = wdata[IM_LSB +: NIRQ];
                end else if (reg_sel == CP0_CAUSE) begin
                    ip_d  = wdata[IP_LSB +: NIRQ];
                end else if (reg_sel == CP0_EPC) begin
                    epc_d = wdata;
                end
            end
            default: ;
        endcase
        ip_d = ip_d | irqRise;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ie_q  <= 1'b0;
            exl_q <= 1'b0;
            im_q  <= '0;
            ip_q  <= '0;
            exc_q <= '0;
            epc_q <= '0;
        end else begin
            ie_q  <= ie_d;
            exl_q <= exl_d;
            im_q  <= im_d;
            ip_q  <= ip_d;
            exc_q <= exc_d;
            epc_q <= epc_d;
        end
    end

    always_comb begin
        statusWord                   = '0;
        statusWord[IE_BIT]           = ie_q;
        statusWord[EXL_BIT]          = exl_q;
        statusWord[IM_LSB +: NIRQ]   = im_q;
        causeWord                    = '0;
        causeWord[IP_LSB +: NIRQ]    = ip_q;
        causeWord[EXC_LSB +: 5]      = exc_q;
    end

    // Reads return the register as it stood before this edge; a same-cycle mtc0
    // is deliberately not forwarded.
    always_comb begin
        rdata = '0;
        if (mfc0 && !rst) begin
            case (reg_sel)
                CP0_STATUS: rdata = statusWord;
                CP0_CAUSE:  rdata = causeWord;
                CP0_EPC:    rdata = epc_q;
                default:    rdata = '0;
            endcase
        end
    end

    // ERET returns to the pre-edge EPC; both exception kinds enter the common vector.
    always_comb begin
        redirect    = (evt == EV_INT) || (evt == EV_SYS) || (evt == EV_ERET);
        kill        = (evt == EV_INT) || (evt == EV_SYS);
        redirect_pc = '0;
        if (evt == EV_ERET)                        redirect_pc = epc_q;
        else if (evt == EV_INT || evt == EV_SYS)   redirect_pc = EXC_VECTOR;
    end

    assign exl = exl_q;

endmodule

// File: tb/tb_cp0_unit.sv
// Self-checking bench for cp0_unit: directed scenarios with constant expectations,
// followed by a randomized run checked against a field-level model of CP0.
module tb_cp0_unit;

    localparam int NIRQ = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            stall;
    logic            mfc0;
    logic            mtc0;
    logic            exce_ret;
    logic            sys;
    logic [4:0]      reg_sel;
    logic [31:0]     wdata;
    logic [31:0]     pc;
    logic [NIRQ-1:0] irq;
    logic [31:0]     rdata;
    logic            redirect;
    logic [31:0]     redirect_pc;
    logic            kill;
    logic            exl;

    int total = 0;
    int bad   = 0;

    cp0_unit #(
        .NIRQ       (NIRQ),
        .EXC_VECTOR (32'h0000_0800)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .mfc0        (mfc0),
        .mtc0        (mtc0),
        .exce_ret    (exce_ret),
        .sys         (sys),
        .reg_sel     (reg_sel),
        .wdata       (wdata),
        .pc          (pc),
        .irq         (irq),
        .rdata       (rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .kill        (kill),
        .exl         (exl)
    );

    always #5 clk = ~clk;

    // Inputs change only on the falling edge so the rising edge sees them settled.
    task automatic applyStimulus(input logic r, input logic st, input logic mf,
                                 input logic mt, input logic er, input logic sy,
                                 input logic [4:0] sel, input logic [31:0] wd,
                                 input logic [31:0] pcv);
        rst = r; stall = st; mfc0 = mf; mtc0 = mt; exce_ret = er; sys = sy;
        reg_sel = sel; wdata = wd; pc = pcv;
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    endtask

    task automatic doReset;
        irq = '0;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        tick;
        tick;
        idle;
    endtask

    task automatic readReg(input logic [4:0] sel);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, sel, 32'h0, 32'h0);
        #1;
    endtask

    task automatic test_reset;
        irq = '1;
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 5'd12, 32'hffff_ffff, 32'h40);
        #1;
        total++; if (redirect !== 1'b0) begin bad++; $display("[TB] FAIL reset_cycle_redirect: got %b expected 0", redirect); end
        total++; if (kill !== 1'b0) begin bad++; $display("[TB] FAIL reset_cycle_kill: got %b expected 0", kill); end
        tick;
        tick;
        irq = '0;
        readReg(5'd12);
        total++; if (rdata !== 32'h0) begin bad++; $display("[TB] FAIL reset_status: got %h expected 0", rdata); end
        readReg(5'd13);
        total++; if (rdata !== 32'h0) begin bad++; $display("[TB] FAIL reset_cause: got %h expected 0", rdata); end
        readReg(5'd14);
        total++; if (rdata !== 32'h0) begin bad++; $display("[TB] FAIL reset_epc: got %h expected 0", rdata); end
        total++; if (exl !== 1'b0) begin bad++; $display("[TB] FAIL reset_exl: got %b expected 0", exl); end
        total++; if (redirect !== 1'b0) begin bad++; $display("[TB] FAIL reset_redirect: got %b expected 0", redirect); end
    endtask

    task automatic test_interrupt;
        doReset;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd12, 32'h0000_0101, 32'h100);
        tick;
        idle;
        irq[0] = 1'b1;
        #1;
        total++; if (redirect !== 1'b0) begin bad++; $display("[TB] FAIL int_early_redirect: got %b expected 0", redirect); end
        tick;
        tick;
        readReg(5'd13);
        total++; if (rdata !== 32'h0) begin bad++; $display("[TB] FAIL int_ip_latency: got %h expected 0", rdata); end
        total++; if (redirect !== 1'b0) begin bad++; $display("[TB] FAIL int_redirect_latency: got %b expected 0", redirect); end
        tick;
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd13, 32'h0, 32'h120);
        #1;
        total++; if (rdata !== 32'h0000_0100) begin bad++; $display("[TB] FAIL int_ip_set: got %h expected 00000100", rdata); end
        total++; if (redirect !== 1'b1) begin bad++; $display("[TB] FAIL int_redirect: got %b expected 1", redirect); end
        total++; if (redirect_pc !== 32'h800) begin bad++; $display("[TB] FAIL int_redirect_pc: got %h expected 00000800", redirect_pc); end
        total++; if (kill !== 1'b1) begin bad++; $display("[TB] FAIL int_kill: got %b expected 1", kill); end
        tick;
        idle;
        #1;
        total++; if (exl !== 1'b1) begin bad++; $display("[TB] FAIL int_exl: got %b expected 1", exl); end
        total++; if (redirect !== 1'b0) begin bad++; $display("[TB] FAIL int_masked_by_exl: got %b expected 0", redirect); end
        readReg(5'd14);
        total++; if (rdata !== 32'h120) begin bad++; $display("[TB] FAIL int_epc: got %h expected 00000120", rdata); end
        readReg(5'd13);
        total++; if (rdata !== 32'h100) begin bad++; $display("[TB] FAIL int_cause: got %h expected 00000100", rdata); end
        readReg(5'd12);
        total++; if (rdata !== 32'h103) begin bad++; $display("[TB] FAIL int_status: got %h expected 00000103", rdata); end
    endtask

    task automatic test_syscall_eret;
        doReset;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 32'h0, 32'h40);
        #1;
        total++; if (redirect !== 1'b1) begin bad++; $display("[TB] FAIL sys_redirect: got %b expected 1", redirect); end
        total++; if (redirect_pc !== 32'h800) begin bad++; $display("[TB] FAIL sys_redirect_pc: got %h expected 00000800", redirect_pc); end
        total++; if (kill !== 1'b1) begin bad++; $display("[TB] FAIL sys_kill: got %b expected 1", kill); end
        tick;
        idle;
        #1;
        total++; if (exl !== 1'b1) begin bad++; $display("[TB] FAIL sys_exl: got %b expected 1", exl); end
        readReg(5'd14);
        total++; if (rdata !== 32'h40) begin bad++; $display("[TB] FAIL sys_epc: got %h expected 00000040", rdata); end
        readReg(5'd13);
        total++; if (rdata !== 32'h20) begin bad++; $display("[TB] FAIL sys_cause: got %h expected 00000020", rdata); end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd14, 32'h44, 32'h804);
        tick;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 32'h808);
        #1;
        total++; if (redirect !== 1'b1) begin bad++; $display("[TB] FAIL eret_redirect: got %b expected 1", redirect); end
        total++; if (redirect_pc !== 32'h44) begin bad++; $display("[TB] FAIL eret_redirect_pc: got %h expected 00000044", redirect_pc); end
        total++; if (kill !== 1'b0) begin bad++; $display("[TB] FAIL eret_kill: got %b expected 0", kill); end
        tick;
        idle;
        #1;
        total++; if (exl !== 1'b0) begin bad++; $display("[TB] FAIL eret_exl: got %b expected 0", exl); end
    endtask

    task automatic test_priority;
        doReset;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd12, 32'h0000_0101, 32'h100);
        tick;
        idle;
        irq[0] = 1'b1;
        tick;
        tick;
        tick;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 32'h0, 32'h200);
        #1;
        total++; if (redirect !== 1'b1) begin bad++; $display("[TB] FAIL prio_redirect: got %b expected 1", redirect); end
        total++; if (kill !== 1'b1) begin bad++; $display("[TB] FAIL prio_kill: got %b expected 1", kill); end
        tick;
        readReg(5'd13);
        total++; if (rdata !== 32'h100) begin bad++; $display("[TB] FAIL prio_cause_int: got %h expected 00000100", rdata); end
        readReg(5'd14);
        total++; if (rdata !== 32'h200) begin bad++; $display("[TB] FAIL prio_epc: got %h expected 00000200", rdata); end
    endtask

    task automatic test_nested;
        doReset;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 32'h0, 32'h40);
        tick;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 32'h0, 32'h900);
        #1;
        total++; if (redirect !== 1'b1) begin bad++; $display("[TB] FAIL nested_redirect: got %b expected 1", redirect); end
        total++; if (redirect_pc !== 32'h800) begin bad++; $display("[TB] FAIL nested_redirect_pc: got %h expected 00000800", redirect_pc); end
        tick;
        readReg(5'd14);
        total++; if (rdata !== 32'h40) begin bad++; $display("[TB] FAIL nested_epc_kept: got %h expected 00000040", rdata); end
        readReg(5'd13);
        total++; if (rdata !== 32'h20) begin bad++; $display("[TB] FAIL nested_cause: got %h expected 00000020", rdata); end
        total++; if (exl !== 1'b1) begin bad++; $display("[TB] FAIL nested_exl: got %b expected 1", exl); end
    endtask

    task automatic test_stall;
        doReset;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd12, 32'h0000_0101, 32'h100);
        tick;
        irq = 4'b0010;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 5'd14, 32'h0000_dead, 32'h300);
        #1;
        total++; if (redirect !== 1'b0) begin bad++; $display("[TB] FAIL stall_redirect: got %b expected 0", redirect); end
        total++; if (kill !== 1'b0) begin bad++; $display("[TB] FAIL stall_kill: got %b expected 0", kill); end
        tick;
        tick;
        tick;
        tick;
        readReg(5'd14);
        total++; if (rdata !== 32'h0) begin bad++; $display("[TB] FAIL stall_epc_held: got %h expected 0", rdata); end
        readReg(5'd13);
        total++; if (rdata !== 32'h200) begin bad++; $display("[TB] FAIL stall_ip_set: got %h expected 00000200", rdata); end
        readReg(5'd12);
        total++; if (rdata !== 32'h101) begin bad++; $display("[TB] FAIL stall_status_held: got %h expected 00000101", rdata); end
        total++; if (exl !== 1'b0) begin bad++; $display("[TB] FAIL stall_exl: got %b expected 0", exl); end
    endtask

    task automatic test_edge_vs_clear;
        doReset;
        irq = 4'b0100;
        tick;
        tick;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd13, 32'h0, 32'h100);
        tick;
        readReg(5'd13);
        total++; if (rdata !== 32'h400) begin bad++; $display("[TB] FAIL edge_beats_clear: got %h expected 00000400", rdata); end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd13, 32'h0, 32'h104);
        tick;
        readReg(5'd13);
        total++; if (rdata !== 32'h0) begin bad++; $display("[TB] FAIL ip_clear: got %h expected 0", rdata); end
    endtask

    // Field-level CP0 model: each rule of the programmer's view applied in order,
    // with the interrupt path seen as "line was high two edges ago and low three ago".
    task automatic test_random;
        logic            mIe, mExl;
        logic [NIRQ-1:0] mIm, mIp, newIp, rise;
        logic [4:0]      mExc;
        logic [31:0]     mEpc;
        logic [NIRQ-1:0] samples[$];
        logic            r, st, mf, mt, er, sy;
        logic [4:0]      sel;
        logic [31:0]     wd, pcv, expRdata, expPc;
        logic            eInt, eSys, eEret, eMtc, expRedir, expKill;

        doReset;
        mIe = 0; mExl = 0; mIm = '0; mIp = '0; mExc = '0; mEpc = '0;
        samples.delete();
        for (int k = 0; k < 3; k++) samples.push_back('0);

        for (int n = 0; n < 800; n++) begin
            r  = ($urandom_range(0, 79) == 0);
            st = ($urandom_range(0, 4) == 0);
            mf = ($urandom_range(0, 2) == 0);
            mt = ($urandom_range(0, 3) == 0);
            er = ($urandom_range(0, 7) == 0);
            sy = ($urandom_range(0, 7) == 0);
            case ($urandom_range(0, 3))
                0:       sel = 5'd12;
                1:       sel = 5'd13;
                2:       sel = 5'd14;
                default: sel = 5'($urandom);
            endcase
            wd  = $urandom;
            pcv = $urandom & 32'hffff_fffc;
            for (int b = 0; b < NIRQ; b++)
                if ($urandom_range(0, 5) == 0) irq[b] = ~irq[b];
            applyStimulus(r, st, mf, mt, er, sy, sel, wd, pcv);
            #1;

            eInt  = !r && !st && mIe && !mExl && ((mIp & mIm) != '0);
            eSys  = !r && !st && !eInt && sy;
            eEret = !r && !st && !eInt && !sy && er;
            eMtc  = !r && !st && !eInt && !sy && !er && mt;
            expRedir = eInt || eSys || eEret;
            expKill  = eInt || eSys;
            expPc    = eEret ? mEpc : 32'h800;
            expRdata = 32'h0;
            if (!r && mf) begin
                if (sel == 5'd12)      expRdata = 32'(mIe) + 32'(mExl) * 2 + 32'(mIm) * 256;
                else if (sel == 5'd13) expRdata = 32'(mIp) * 256 + 32'(mExc) * 4;
                else if (sel == 5'd14) expRdata = mEpc;
            end

            total++; if (redirect !== expRedir) begin bad++; $display("[TB] FAIL rand_redirect cycle %0d: got %b expected %b", n, redirect, expRedir); end
            total++; if (kill !== expKill) begin bad++; $display("[TB] FAIL rand_kill cycle %0d: got %b expected %b", n, kill, expKill); end
            total++; if (rdata !== expRdata) begin bad++; $display("[TB] FAIL rand_rdata cycle %0d: got %h expected %h", n, rdata, expRdata); end
            total++; if (exl !== mExl) begin bad++; $display("[TB] FAIL rand_exl cycle %0d: got %b expected %b", n, exl, mExl); end
            if (expRedir) begin
                total++; if (redirect_pc !== expPc) begin bad++; $display("[TB] FAIL rand_redirect_pc cycle %0d: got %h expected %h", n, redirect_pc, expPc); end
            end

            if (r) begin
                mIe = 0; mExl = 0; mIm = '0; mIp = '0; mExc = '0; mEpc = '0;
                samples.delete();
                for (int k = 0; k < 3; k++) samples.push_back('0);
            end else begin
                rise  = samples[1] & ~samples[0];
                newIp = mIp;
                if (eInt) begin
                    mEpc = pcv; mExc = 5'd0; mExl = 1'b1;
                end else if (eSys) begin
                    if (!mExl) mEpc = pcv;
                    mExc = 5'd8; mExl = 1'b1;
                end else if (eEret) begin
                    mExl = 1'b0;
                end else if (eMtc) begin
                    if (sel == 5'd12) begin
                        mIe = wd[0]; mExl = wd[1]; mIm = wd[11:8];
                    end else if (sel == 5'd13) begin
                        newIp = wd[11:8];
                    end else if (sel == 5'd14) begin
                        mEpc = wd;
                    end
                end
                mIp = newIp | rise;
                void'(samples.pop_front());
                samples.push_back(irq);
            end
            tick;
        end
        idle;
        irq = '0;
    endtask

    initial begin
        irq = '0;
        idle;
        @(negedge clk);
        test_reset;
        test_interrupt;
        test_syscall_eret;
        test_priority;
        test_nested;
        test_stall;
        test_edge_vs_clear;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
